// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the arbiter, and the single shared ALU.
// slave = arbiter side, master = requester side, alu = ALU side.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [3:0]  aluop0, aluop1;
  logic [31:0] porta0, portb0, porta1, portb1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] result;
  logic        negative, overflow, zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_negative, alu_overflow, alu_zero;

  modport slave (
    input  req0, req1, aluop0, aluop1, porta0, portb0, porta1, portb1,
    input  alu_out, alu_negative, alu_overflow, alu_zero,
    output gnt0, gnt1, done0, done1, result, negative, overflow, zero,
    output alu_op, alu_a, alu_b
  );

  modport master (
    output req0, req1, aluop0, aluop1, porta0, portb0, porta1, portb1,
    input  gnt0, gnt1, done0, done1, result, negative, overflow, zero
  );

  modport alu (
    input  alu_op, alu_a, alu_b,
    output alu_out, alu_negative, alu_overflow, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One transaction in flight: grant in IDLE, capture ALU in EXEC, respond in RESP.
module alu_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input logic          CLK,
  input logic          nRST,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        neg_q, neg_d, ovf_q, ovf_d, zero_q, zero_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        grant_valid, grant_sel;

  always_comb begin
    grant_valid = (state_q == IDLE) && (bus.req0 || bus.req1);
    // Pointer only matters on contention; a lone requester always wins.
    grant_sel   = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done0_d = 1'b0;
    done1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = EXEC;
          win_d   = grant_sel;
          op_d    = grant_sel ? bus.aluop1 : bus.aluop0;
          a_d     = grant_sel ? bus.porta1 : bus.porta0;
          b_d     = grant_sel ? bus.portb1 : bus.portb0;
        end
      end
      EXEC: begin
        state_d = RESP;
        res_d   = bus.alu_out;
        neg_d   = bus.alu_negative;
        ovf_d   = bus.alu_overflow;
        zero_d  = bus.alu_zero;
        done0_d = ~win_q;
        done1_d = win_q;
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = ~win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= PRIO_RESET;
      win_q   <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // Grants are same-cycle pulses; nRST gates them so reset silences them at once.
  assign bus.gnt0     = nRST && grant_valid && !grant_sel;
  assign bus.gnt1     = nRST && grant_valid &&  grant_sel;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.result   = res_q;
  assign bus.negative = neg_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.alu_op   = op_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
endmodule
